// File: rtl/uart_frame_tx.sv
// UART response framer: sends "55d5" followed by four lowercase hex characters of din as 8N1.
// Define UART_FRAME_TX_PEND_EN to add a one-entry pending request register.
module uart_frame_tx #(
  parameter int         BPS  = 5208,
  parameter logic [7:0] HDR0 = 8'h35,
  parameter logic [7:0] HDR1 = 8'h35,
  parameter logic [7:0] HDR2 = 8'h64,
  parameter logic [7:0] HDR3 = 8'h35
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_vld,
  output logic        rdy,
  output logic        busy,
  output logic        frame_done,
  output logic        tx_uart
);

  localparam int CW = (BPS > 2) ? $clog2(BPS) : 1;
  localparam logic [CW-1:0] BPS_LAST = CW'(BPS - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e        state_q;
  logic [CW-1:0] bps_cnt_q;
  logic [3:0]    bit_cnt_q;
  logic [2:0]    byte_cnt_q;
  logic [15:0]   data_q;
  logic          tx_q, busy_q, done_q, rdy_q;
`ifdef UART_FRAME_TX_PEND_EN
  logic [15:0]   pend_q;
  logic          pend_full_q;
`endif

  logic [7:0] cur_byte_d;
  logic       tx_bit_d;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'd0, n};
    else           return 8'h57 + {4'd0, n};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [15:0] v);
    case (idx)
      3'd0:    return HDR0;
      3'd1:    return HDR1;
      3'd2:    return HDR2;
      3'd3:    return HDR3;
      3'd4:    return hex_char(v[15:12]);
      3'd5:    return hex_char(v[11:8]);
      3'd6:    return hex_char(v[7:4]);
      default: return hex_char(v[3:0]);
    endcase
  endfunction

  // Level of the bit that starts when bit_cnt_q advances: data bit bit_cnt_q, or stop after bit 7.
  always_comb begin
    cur_byte_d = frame_byte(byte_cnt_q, data_q);
    tx_bit_d   = 1'b1;
    if (bit_cnt_q < 4'd8) tx_bit_d = cur_byte_d[bit_cnt_q[2:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bps_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdy_q       <= 1'b1;
`ifdef UART_FRAME_TX_PEND_EN
      pend_full_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (din_vld) begin
            data_q     <= din;
            state_q    <= SEND;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            bps_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
`ifndef UART_FRAME_TX_PEND_EN
            rdy_q      <= 1'b0;
`endif
          end
        end
        SEND: begin
`ifdef UART_FRAME_TX_PEND_EN
          if (din_vld && !pend_full_q) begin
            pend_q      <= din;
            pend_full_q <= 1'b1;
            rdy_q       <= 1'b0;
          end
`endif
          if (bps_cnt_q == BPS_LAST) begin
            bps_cnt_q <= '0;
            if (bit_cnt_q == 4'd9) begin
              bit_cnt_q <= '0;
              if (byte_cnt_q == 3'd7) begin
                byte_cnt_q <= '0;
                done_q     <= 1'b1;
`ifdef UART_FRAME_TX_PEND_EN
                // Chain straight into the next frame; a request arriving right now skips the pending slot.
                if (pend_full_q || din_vld) begin
                  data_q      <= pend_full_q ? pend_q : din;
                  pend_full_q <= 1'b0;
                  rdy_q       <= 1'b1;
                  tx_q        <= 1'b0;
                end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  tx_q    <= 1'b1;
                end
`else
                state_q <= IDLE;
                busy_q  <= 1'b0;
                rdy_q   <= 1'b1;
                tx_q    <= 1'b1;
`endif
              end else begin
                byte_cnt_q <= byte_cnt_q + 3'd1;
                tx_q       <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              tx_q      <= tx_bit_d;
            end
          end else begin
            bps_cnt_q <= bps_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdy        = rdy_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign tx_uart    = tx_q;

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Response-side framer for the temperature monitor's UART link; the transmit counterpart of the command receiver that parses "55d5" + 4 ASCII characters.
- Accepts a 16-bit value (temperature or status word), converts it to 4 lowercase ASCII hex characters and prepends the fixed header "5","5","d","5".
- Serialises the resulting 8 bytes as 8N1 UART on tx_uart at BPS clocks per bit.
- Sits between the DS18B20 result path and the board TX pin.

Parameters:
- BPS, 5208, clock cycles per UART bit (50 MHz / 9600 baud); must be >= 2.
- HDR0, "5", first header byte (8'h35).
- HDR1, "5", second header byte (8'h35).
- HDR2, "d", third header byte (8'h64).
- HDR3, "5", fourth header byte (8'h35).

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  reset, synchronous, active-high.
- din  input  16  value to report.
- din_vld  input  1  single-cycle request; din is sampled when din_vld=1 and rdy=1.
- rdy  output  1  1 when a request will be accepted this cycle.
- busy  output  1  1 while a frame is being shifted out.
- frame_done  output  1  one-cycle pulse after the last stop bit completes.
- tx_uart  output  1  serial line; idles high.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values: tx_uart=1, busy=0, frame_done=0, rdy=1. All counters are zero and the state is IDLE.
- Reset asserted mid-frame aborts the frame. tx_uart returns to 1 on the next edge, and no frame_done is issued.
- States:
  - IDLE: rdy=1, busy=0, tx_uart=1.
  - SEND: rdy=0, busy=1.
- IDLE to SEND: on an edge where din_vld=1.
  - din is latched into the shift source.
  - On the following cycle tx_uart=0 (start bit of byte 0) and busy=1. Latency from accept to start bit is 1 cycle.
- Byte order:
  - Bytes 0 to 3 are HDR0..HDR3.
  - Byte 4 is the hex character of din[15:12], byte 5 of din[11:8], byte 6 of din[7:4], byte 7 of din[3:0].
- Hex mapping: nibble 0-9 maps to 8'h30-8'h39; nibble a-f maps to 8'h61-8'h66. Lowercase only.
- Byte format: start bit 0, data bits LSB first, stop bit 1. Each bit is held exactly BPS cycles.
- Bytes are sent back-to-back with no idle gap. A frame is exactly 80*BPS cycles of busy=1.
- Counters:
  - Bit-time counter: 0..BPS-1.
  - Bit counter: 0..9.
  - Byte counter: 0..7.
  - Each counter wraps and advances the next counter only at its terminal count.
- SEND to IDLE: at the end of the stop bit of byte 7.
  - frame_done=1 for exactly that one following cycle.
  - busy=0 and rdy=1 in the same cycle. tx_uart stays 1.
- din_vld while busy (macro undefined): the request is ignored, din is not sampled, and the frame in flight is unaffected.
- din_vld in the same cycle frame_done=1: accepted (rdy=1). The next start bit follows one cycle later, giving a 1-cycle idle-high gap between frames.
- din changes after acceptance have no effect on the frame in flight.

Optional Feature:
- Macro: UART_FRAME_TX_PEND_EN.
- Defined:
  - Adds a one-entry pending register.
  - rdy = !pend_full, so rdy stays 1 during the first request's frame.
  - A din_vld accepted while busy is stored in the pending register.
  - At frame end, SEND reloads directly from pending with no IDLE cycle; byte 0's start bit follows the last stop bit immediately.
  - frame_done still pulses for each completed frame.
  - A request arriving while pending is full is dropped (rdy=0).
  - Reset clears the pending register.
- Undefined: behaviour is exactly as above, with rdy = !busy.

Test Plan:
- Reset held 3 cycles, then released: tx_uart=1, busy=0, rdy=1, frame_done=0. Apply rst mid-frame: tx_uart=1 on the next edge and no frame_done.
- BPS=4, din=16'h01a9, din_vld pulse: start bit 1 cycle later. Receiver model decodes 35,35,64,35,30,31,61,39 ("55d501a9"). busy high exactly 320 cycles, then frame_done pulses once.
- din=16'hffff then 16'h0000: characters 66,66,66,66 and 30,30,30,30. Every bit width measures exactly 4 cycles, including the stop bit of byte 7.
- din_vld=1 with din=16'h1234 at mid-frame of a 16'h00ff frame (macro off): output is only "55d500ff"; no second frame; rdy=0 throughout.
- din_vld asserted in the frame_done cycle with din=16'hbeef: accepted. One idle-high cycle, then "55d5beef".
- Macro on: issue 16'h0001, then 16'h0002 and 16'h0003 during the first frame. Frames "55d50001" and "55d50002" are sent back-to-back with zero gap, 16'h0003 is dropped, and frame_done pulses twice.
